fifo_write_arbiter: RTL and testbench

//  Shares the single write port of one simple_fifo between NREQ producers.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_priority_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

   // Modular increment done by compare so non-power-of-2 counts wrap correctly
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
   parameter int N    = 4,
   parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic            any,
   output logic [IDXW-1:0] idx
);

   int pos;

   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!any && req[pos[IDXW-1:0]]) begin
            any = 1'b1;
            idx = pos[IDXW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NREQ producers,
// holding each grant for a burst of up to BURST words.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int BURST = 4,
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       in_valid,
   input  logic [NREQ*WIDTH-1:0] in_data,
   output logic [NREQ-1:0]       in_ack,
   output logic                  fifo_wr,
   output logic [WIDTH-1:0]      fifo_wdata,
   input  logic                  fifo_not_full,
   output logic                  grant_valid,
   output logic [IDXW-1:0]       grant_idx
);

   localparam int BW = $clog2(BURST) + 1;

   arb_state_t      state_q, state_d;
   logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDXW-1:0] grant_q, grant_d;
   logic [BW-1:0]   beats_q, beats_d;
   logic            pick_any;
   logic [IDXW-1:0] pick_idx;
   logic [IDXW-1:0] rr_after_grant;
   logic [WIDTH-1:0] words [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         words[i] = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign rr_after_grant = IDXW'(rr_next(32'(grant_q), 32'(NREQ)));

   rr_priority_pick #(.N(NREQ), .IDXW(IDXW)) u_pick (
      .req (in_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         beats_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         beats_q  <= beats_d;
      end
   end

   // Outputs are decoded from the registered state, so an async reset silences them at once
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      beats_d     = beats_q;
      in_ack      = '0;
      fifo_wr     = 1'b0;
      fifo_wdata  = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               beats_d = '0;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            grant_valid = 1'b1;
            grant_idx   = grant_q;
            fifo_wdata  = words[grant_q];
            if (in_valid[grant_q]) begin
               if (fifo_not_full) begin
                  fifo_wr         = 1'b1;
                  in_ack[grant_q] = 1'b1;
                  if (beats_q == BW'(BURST - 1)) begin
                     state_d  = ARB_IDLE;
                     rr_ptr_d = rr_after_grant;
                     beats_d  = '0;
                  end else begin
                     beats_d = beats_q + 1'b1;
                  end
               end
            end else begin
               state_d  = ARB_IDLE;
               rr_ptr_d = rr_after_grant;
               beats_d  = '0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scoreboard bench for fifo_write_arbiter (NREQ=4/BURST=4 and NREQ=3/BURST=1 instances).
module tb_fifo_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic        fifo_not_full;

   logic [3:0]  in_ack4;
   logic        fifo_wr4;
   logic [7:0]  fifo_wdata4;
   logic        grant_valid4;
   logic [1:0]  grant_idx4;

   logic [2:0]  in_ack3;
   logic        fifo_wr3;
   logic [7:0]  fifo_wdata3;
   logic        grant_valid3;
   logic [1:0]  grant_idx3;

   fifo_write_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) u_dut4 (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ack        (in_ack4),
      .fifo_wr       (fifo_wr4),
      .fifo_wdata    (fifo_wdata4),
      .fifo_not_full (fifo_not_full),
      .grant_valid   (grant_valid4),
      .grant_idx     (grant_idx4)
   );

   fifo_write_arbiter #(.NREQ(3), .WIDTH(8), .BURST(1)) u_dut3 (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid[2:0]),
      .in_data       (in_data[23:0]),
      .in_ack        (in_ack3),
      .fifo_wr       (fifo_wr3),
      .fifo_wdata    (fifo_wdata3),
      .fifo_not_full (fifo_not_full),
      .grant_valid   (grant_valid3),
      .grant_idx     (grant_idx3)
   );

   // Observed interface follows whichever instance the current test targets
   logic       sel3;
   logic [3:0] m_ack;
   logic       m_wr;
   logic [7:0] m_wdata;
   logic       m_gv;
   logic [1:0] m_gi;

   assign m_ack   = sel3 ? {1'b0, in_ack3} : in_ack4;
   assign m_wr    = sel3 ? fifo_wr3        : fifo_wr4;
   assign m_wdata = sel3 ? fifo_wdata3     : fifo_wdata4;
   assign m_gv    = sel3 ? grant_valid3    : grant_valid4;
   assign m_gi    = sel3 ? grant_idx3      : grant_idx4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   logic [7:0] src_q [4][$];
   logic [7:0] exp_q [4][$];
   logic [3:0] en;
   logic [3:0] ack_seen;
   logic       stall_chk;
   logic       prev_gv;
   logic [31:0] wr_hist;
   logic [31:0] gv_hist;
   int gseq [$];
   int wcount [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         in_valid[i]       = en[i] && (src_q[i].size() > 0);
         in_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
   endtask

   // Producer i presents word w; the same word is expected at the fifo in order
   task automatic applyStimulus(input int p, input logic [7:0] w);
      src_q[p].push_back(w);
      exp_q[p].push_back(w);
   endtask

   task automatic clear_logs();
      wr_hist = '0;
      gv_hist = '0;
      prev_gv = 1'b0;
      gseq.delete();
      wcount.delete();
   endtask

   task automatic checkOutput();
      int p;
      logic [7:0] e;
      check("no_wr_when_full", 32'(m_wr & ~fifo_not_full), 0);
      if (m_wr) begin
         p = int'(m_gi);
         check("ack_onehot", 32'(m_ack), 32'(4'b0001 << m_gi));
         check("word_expected", 32'(exp_q[p].size() > 0), 1);
         if (exp_q[p].size() > 0) begin
            e = exp_q[p].pop_front();
            check("wdata", 32'(m_wdata), 32'(e));
         end
      end else begin
         check("ack_idle", 32'(m_ack), 0);
      end
      if (stall_chk) begin
         check("stall_gv", 32'(m_gv), 1);
         check("stall_gidx", 32'(m_gi), 2);
         check("stall_wr", 32'(m_wr), 0);
      end
      if (m_gv && !prev_gv) begin
         gseq.push_back(int'(m_gi));
         wcount.push_back(0);
      end
      if (m_wr && wcount.size() > 0) wcount[wcount.size()-1]++;
      prev_gv = m_gv;
      wr_hist = {wr_hist[30:0], m_wr};
      gv_hist = {gv_hist[30:0], m_gv};
   endtask

   task automatic cycle();
      @(negedge clk);
      checkOutput();
      ack_seen = m_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (ack_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive_inputs();
   endtask

   task automatic applyReset();
      reset = 1'b1;
      en = 4'b0000;
      fifo_not_full = 1'b1;
      stall_chk = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_logs();
   endtask

   int remaining;
   int budget;

   initial begin
      tests_run = 0;
      tests_failed = 0;
      sel3 = 1'b0;
      applyReset();

      // Reset state
      @(negedge clk);
      check("rst_gv", 32'(m_gv), 0);
      check("rst_wr", 32'(m_wr), 0);
      check("rst_ack", 32'(m_ack), 0);
      check("rst_gidx", 32'(m_gi), 0);
      check("rst_wdata", 32'(m_wdata), 0);
      @(posedge clk);
      #1;

      // 1: single producer streams 10 words -> bursts 4/4/2 with dead cycles
      $display("[TB] test 1: single producer bursts");
      for (int k = 0; k < 10; k++) applyStimulus(0, 8'(k));
      en = 4'b0001;
      drive_inputs();
      repeat (13) cycle();
      check("t1_wr_pattern", {19'b0, wr_hist[12:0]}, {19'b0, 13'b0111101111011});
      check("t1_drained", 32'(exp_q[0].size()), 0);

      // 2: all producers valid -> grants 0,1,2,3,0,1 with 4 writes each
      $display("[TB] test 2: all producers round robin");
      applyReset();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 8; k++) applyStimulus(i, 8'(i*16 + k));
      en = 4'b1111;
      drive_inputs();
      repeat (30) cycle();
      check("t2_ngrants", 32'(gseq.size()), 6);
      for (int g = 0; g < 6 && g < gseq.size(); g++) begin
         check($sformatf("t2_grant%0d", g), 32'(gseq[g]), 32'(g % 4));
         check($sformatf("t2_writes%0d", g), 32'(wcount[g]), 4);
      end

      // 3: fifo full for 5 cycles after prod2's 2nd word
      $display("[TB] test 3: fifo stall mid burst");
      applyReset();
      for (int k = 0; k < 8; k++) applyStimulus(2, 8'(8'h20 + k));
      for (int k = 0; k < 4; k++) applyStimulus(3, 8'(8'h30 + k));
      en = 4'b1100;
      drive_inputs();
      repeat (3) cycle();
      fifo_not_full = 1'b0;
      stall_chk = 1'b1;
      repeat (5) cycle();
      fifo_not_full = 1'b1;
      stall_chk = 1'b0;
      repeat (4) cycle();
      check("t3_ngrants", 32'(gseq.size()), 2);
      if (gseq.size() >= 2) begin
         check("t3_first", 32'(gseq[0]), 2);
         check("t3_burst", 32'(wcount[0]), 4);
         check("t3_next", 32'(gseq[1]), 3);
      end

      // 4: prod1 drops valid after 2 words -> release, then prod3 (not prod0)
      $display("[TB] test 4: early release");
      applyReset();
      applyStimulus(1, 8'h11);
      applyStimulus(1, 8'h12);
      applyStimulus(0, 8'h01);
      applyStimulus(0, 8'h02);
      applyStimulus(3, 8'h31);
      applyStimulus(3, 8'h32);
      en = 4'b0010;
      drive_inputs();
      repeat (3) cycle();
      en = 4'b1011;
      drive_inputs();
      repeat (3) cycle();
      check("t4_gv_pattern", {26'b0, gv_hist[5:0]}, {26'b0, 6'b011101});
      check("t4_wr_pattern", {26'b0, wr_hist[5:0]}, {26'b0, 6'b011001});
      check("t4_ngrants", 32'(gseq.size()), 2);
      if (gseq.size() >= 2) check("t4_second", 32'(gseq[1]), 3);

      // 5: asynchronous reset mid-burst
      $display("[TB] test 5: async reset mid burst");
      applyReset();
      for (int k = 0; k < 8; k++) applyStimulus(2, 8'(8'h50 + k));
      en = 4'b0100;
      drive_inputs();
      repeat (2) cycle();
      #2;
      check("t5_pre_gv", 32'(m_gv), 1);
      reset = 1'b1;
      #1;
      check("t5_gv", 32'(m_gv), 0);
      check("t5_wr", 32'(m_wr), 0);
      check("t5_ack", 32'(m_ack), 0);
      check("t5_gidx", 32'(m_gi), 0);
      check("t5_wdata", 32'(m_wdata), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      clear_logs();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 8'(8'h60 + k));
         applyStimulus(1, 8'(8'h70 + k));
      end
      en = 4'b0011;
      drive_inputs();
      repeat (3) cycle();
      check("t5_ngrants", 32'(gseq.size()), 1);
      if (gseq.size() >= 1) check("t5_first_after_reset", 32'(gseq[0]), 0);

      // 6: NREQ=3, BURST=1, then random fifo stalls
      $display("[TB] test 6: three producers, single-word bursts");
      sel3 = 1'b1;
      applyReset();
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 6; k++) applyStimulus(i, 8'(8'h80 + i*16 + k));
      en = 4'b0111;
      drive_inputs();
      repeat (12) cycle();
      check("t6_ngrants", 32'(gseq.size()), 6);
      for (int g = 0; g < 6 && g < gseq.size(); g++) begin
         check($sformatf("t6_grant%0d", g), 32'(gseq[g]), 32'(g % 3));
         check($sformatf("t6_writes%0d", g), 32'(wcount[g]), 1);
      end
      budget = 0;
      remaining = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      while (remaining > 0 && budget < 300) begin
         fifo_not_full = 1'($urandom_range(0, 1));
         cycle();
         budget++;
         remaining = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      end
      fifo_not_full = 1'b1;
      check("t6_all_delivered", 32'(remaining), 0);
      repeat (4) cycle();
      check("t6_no_extra", 32'(wr_hist[3:0]), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
